fwd_hazard_ctrl: RTL

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/mips_pkg.sv | 38 +++
 rtl/fwd_match.sv | 26 ++
 rtl/fwd_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: forward-select encodings and the
// hazard-tag bundle carried alongside EX, MEM and WB.
package mips_pkg;

    // Widest register specifier a tag can hold; narrower ports zero-extend.
    localparam int TAG_RW = 8;

    // Select order matches the 3-input operand mux: RF, WB result, MEM ALU.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef logic [TAG_RW-1:0] reg_id_t;

    typedef struct packed {
        logic    valid;
        logic    regwrite;
        logic    memtoreg;
        reg_id_t rd;
        reg_id_t rs;
        reg_id_t rt;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // Live tag whose destination is a real register equal to r.
    function automatic logic tag_hits(tag_t t, reg_id_t r);
        return t.valid && (t.rd != '0) && (t.rd == r);
    endfunction

    // As tag_hits, but the instruction must also write the register file.
    function automatic logic tag_writes(tag_t t, reg_id_t r);
        return t.regwrite && tag_hits(t, r);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Forward-select for one source specifier against the MEM and WB tags.
// MEM is the younger producer, so it wins over WB.
module fwd_match
    import mips_pkg::*;
(
    input  reg_id_t  src,
    input  tag_t     mem_t,
    input  tag_t     wb_t,
    output fwd_sel_e sel
);

    // Fields that play no part in a forwarding decision.
    logic unused_fields;
    assign unused_fields = ^{mem_t.memtoreg, mem_t.rs, mem_t.rt,
                             wb_t.memtoreg, wb_t.rs, wb_t.rt};

    // Later assignment has priority: MEM overrides WB overrides RF.
    always_comb begin
        sel = FWD_RF;
        if (tag_writes(wb_t, src))
            sel = FWD_WB;
        if (tag_writes(mem_t, src))
            sel = FWD_MEM;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage MIPS pipeline.
// Define FWD_ID_BRANCH_EN for ID-stage branch compare forwarding/stalls.
module fwd_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memtoreg,
    input  logic            id_branch,
    input  logic            branch_taken,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e,
    output logic            fwd_a_d,
    output logic            fwd_b_d
);

    // REGW must not exceed TAG_RW; specifiers are zero-extended into tags.
    reg_id_t rs_d;
    reg_id_t rt_d;
    reg_id_t rd_d;

    assign rs_d = TAG_RW'(id_rs);
    assign rt_d = TAG_RW'(id_rt);
    assign rd_d = TAG_RW'(id_rd);

    tag_t id_tag;
    tag_t ex_q;
    tag_t mem_q;
    tag_t wb_q;

    assign id_tag = '{
        valid:    id_valid,
        regwrite: id_regwrite,
        memtoreg: id_memtoreg,
        rd:       rd_d,
        rs:       rs_d,
        rt:       rt_d
    };

    logic load_use;
    logic br_stall;
    logic stall;

    // A load in EX cannot feed a consumer in ID until it reaches WB.
    always_comb begin
        load_use = id_valid && ex_q.memtoreg &&
                   (tag_hits(ex_q, rs_d) || tag_hits(ex_q, rt_d));
    end

    assign stall   = load_use || br_stall;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    // A stalled ID keeps its instruction, so a taken branch waits a cycle.
    assign flush_d = branch_taken && !stall;

    // Tag pipeline: ID -> EX -> MEM -> WB, bubble into EX while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
        end else begin
            ex_q  <= flush_e ? TAG_BUBBLE : id_tag;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    fwd_sel_e sel_a_e;
    fwd_sel_e sel_b_e;

    fwd_match u_match_a_e (
        .src   (ex_q.rs),
        .mem_t (mem_q),
        .wb_t  (wb_q),
        .sel   (sel_a_e)
    );

    fwd_match u_match_b_e (
        .src   (ex_q.rt),
        .mem_t (mem_q),
        .wb_t  (wb_q),
        .sel   (sel_b_e)
    );

    assign fwd_a_e = sel_a_e;
    assign fwd_b_e = sel_b_e;

`ifdef FWD_ID_BRANCH_EN

    fwd_sel_e sel_a_d;
    fwd_sel_e sel_b_d;

    // The branch comparator only taps the MEM ALU result, never WB.
    fwd_match u_match_a_d (
        .src   (rs_d),
        .mem_t (mem_q),
        .wb_t  (TAG_BUBBLE),
        .sel   (sel_a_d)
    );

    fwd_match u_match_b_d (
        .src   (rt_d),
        .mem_t (mem_q),
        .wb_t  (TAG_BUBBLE),
        .sel   (sel_b_d)
    );

    assign fwd_a_d = (sel_a_d == FWD_MEM);
    assign fwd_b_d = (sel_b_d == FWD_MEM);

    logic ex_src_hit;
    logic mem_src_hit;

    // Branch waits for an ALU result still in EX or a load still in MEM.
    always_comb begin
        ex_src_hit  = tag_hits(ex_q, rs_d) || tag_hits(ex_q, rt_d);
        mem_src_hit = tag_hits(mem_q, rs_d) || tag_hits(mem_q, rt_d);
        br_stall    = id_valid && id_branch &&
                      ((ex_q.regwrite && ex_src_hit) ||
                       (mem_q.memtoreg && mem_src_hit));
    end

`else

    // Branch operands come straight from the register file.
    logic unused_branch;
    assign unused_branch = id_branch;

    assign fwd_a_d  = 1'b0;
    assign fwd_b_d  = 1'b0;
    assign br_stall = 1'b0;

`endif

endmodule
